// File: rtl/key_pkg.sv
// Shared constants and helpers for the push-button front end.
// All timing is expressed in board-clock cycles.
package key_pkg;

    localparam int KEY_CLK_HZ = 27_000_000;

    // Convert a duration in milliseconds to board-clock cycles.
    function automatic int ms_to_cycles(input int ms);
        return (KEY_CLK_HZ / 1000) * ms;
    endfunction

    // 20 ms of stability before a level change is accepted.
    localparam int KEY_DEB_CYCLES_DEF  = ms_to_cycles(20);
    // 1 s of continuous hold before a long-press event.
    localparam int KEY_LONG_CYCLES_DEF = ms_to_cycles(1000);

    // Single-cycle event flags produced by one key channel.
    typedef struct packed {
        logic press;
        logic rel;
        logic lng;
    } key_evt_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce counter, hold counter
// and registered single-cycle press / release / long-press events.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int KEY_ACT_HIGH = 1,
    parameter int DEB_CYCLES   = KEY_DEB_CYCLES_DEF,
    parameter int LONG_CYCLES  = KEY_LONG_CYCLES_DEF
) (
    input  logic gclk,
    input  logic gresetn,
    input  logic key_pin,
    output logic level,
    output logic press,
    output logic rel,
    output logic lng
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);

    // Pin level that means "pressed", and its complement (the idle level).
    localparam logic PIN_ACTIVE = (KEY_ACT_HIGH != 0);
    localparam logic PIN_IDLE   = ~PIN_ACTIVE;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYCLES - 2);

    logic            sync1_reg;
    logic            sync2_reg;
    logic            level_reg;
    logic [DW-1:0]   deb_cnt_reg;
    logic [HW-1:0]   hold_cnt_reg;
    key_evt_t        evt_reg;

    logic            pressed;
    logic            commit;

    // Synchronized pin translated to "1 = pressed"; commit when the
    // disagreement has been stable for the full debounce window.
    always_comb begin
        pressed = (sync2_reg == PIN_ACTIVE);
        commit  = (pressed != level_reg) && (deb_cnt_reg == DEB_LAST);
    end

    // Two-flop synchronizer; reset preloads the idle pin level so a key
    // held through reset is seen as a fresh change afterwards.
    always_ff @(posedge gclk) begin
        if (!gresetn) begin
            sync1_reg <= PIN_IDLE;
            sync2_reg <= PIN_IDLE;
        end else begin
            sync1_reg <= key_pin;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce: count cycles of disagreement, any agreement restarts the window.
    always_ff @(posedge gclk) begin
        if (!gresetn) begin
            level_reg   <= 1'b0;
            deb_cnt_reg <= '0;
            evt_reg.press <= 1'b0;
            evt_reg.rel   <= 1'b0;
        end else begin
            evt_reg.press <= 1'b0;
            evt_reg.rel   <= 1'b0;
            if (pressed == level_reg) begin
                deb_cnt_reg <= '0;
            end else if (commit) begin
                level_reg     <= pressed;
                deb_cnt_reg   <= '0;
                evt_reg.press <= pressed;
                evt_reg.rel   <= ~pressed;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    // Hold timer: runs while pressed, saturates, and fires once per press.
    // The release commit edge clears it so a late long event cannot slip out.
    always_ff @(posedge gclk) begin
        if (!gresetn) begin
            hold_cnt_reg <= '0;
            evt_reg.lng  <= 1'b0;
        end else if (!level_reg || commit) begin
            hold_cnt_reg <= '0;
            evt_reg.lng  <= 1'b0;
        end else if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
            evt_reg.lng  <= (hold_cnt_reg == HOLD_PRE);
        end else begin
            evt_reg.lng  <= 1'b0;
        end
    end

    assign level = level_reg;
    assign press = evt_reg.press;
    assign rel   = evt_reg.rel;
    assign lng   = evt_reg.lng;

endmodule

// File: rtl/key_debounce_evt.sv
// Multi-key debouncer: N_KEYS fully independent channels, each producing a
// clean pressed level and single-cycle press / release / long-press pulses.
module key_debounce_evt
    import key_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int KEY_ACT_HIGH = 1,
    parameter int DEB_CYCLES   = KEY_DEB_CYCLES_DEF,
    parameter int LONG_CYCLES  = KEY_LONG_CYCLES_DEF
) (
    input  logic              gclk,
    input  logic              gresetn,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    // One channel per key; no state is shared between channels.
    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
            key_debounce_ch #(
                .KEY_ACT_HIGH (KEY_ACT_HIGH),
                .DEB_CYCLES   (DEB_CYCLES),
                .LONG_CYCLES  (LONG_CYCLES)
            ) u_ch (
                .gclk    (gclk),
                .gresetn (gresetn),
                .key_pin (key[gi]),
                .level   (key_level[gi]),
                .press   (key_press[gi]),
                .rel     (key_release[gi]),
                .lng     (key_long[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce_evt.sv
// Bench for key_debounce_evt with 2 keys, DEB_CYCLES=4, LONG_CYCLES=16.
// Expected events are queued with their expected cycle when stimulus is
// driven; a monitor records every observed pulse and each scenario task
// compares the two queues in order.
module tb_key_debounce_evt;

    localparam int N  = 2;
    localparam int DEB = 4;
    localparam int LNG = 16;
    localparam int LAT = DEB + 2;   // pin change to committed level
    localparam int LONG_LAT = LNG - 1; // commit edge to long pulse edge

    typedef struct packed {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
        logic [1:0] lvl;
    } ev_t;

    logic         gclk = 1'b0;
    logic         gresetn;
    logic [N-1:0] key;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    key_debounce_evt #(
        .N_KEYS       (N),
        .KEY_ACT_HIGH (1),
        .DEB_CYCLES   (DEB),
        .LONG_CYCLES  (LNG)
    ) dut (
        .gclk        (gclk),
        .gresetn     (gresetn),
        .key         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 gclk = ~gclk;

    always @(posedge gclk) cyc <= cyc + 1;

    // Record every cycle carrying any pulse, stamped with its edge number.
    always @(negedge gclk) begin
        if ((key_press | key_release | key_long) != '0)
            obs_q.push_back('{cyc, key_press, key_release, key_long, key_level});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge gclk);
    endtask

    task automatic expect_ev(input int c, input logic [1:0] p, input logic [1:0] r,
                             input logic [1:0] l, input logic [1:0] v);
        exp_q.push_back('{c, p, r, l, v});
    endtask

    task automatic test_reset();
        int t;
        ev_t e, o;
        gresetn = 1'b0;
        key = 2'b00;
        obs_q.delete();
        for (int i = 0; i < 103; i++) begin
            @(negedge gclk);
            if (i == 100) key = 2'b11;
            total++;
            if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
                bad++;
                $display("FAIL reset_quiet: cyc=%0d outputs=%b required 0", cyc,
                         {key_level, key_press, key_release, key_long});
            end
        end
        gresetn = 1'b1;
        t = cyc;
        expect_ev(t + LAT, 2'b11, 2'b00, 2'b00, 2'b11);
        cycles(LAT - 1);
        total++;
        if (key_level !== 2'b00) begin
            bad++;
            $display("FAIL reset_early: key_level=%b required 00", key_level);
        end
        cycles(1);
        total++;
        if (key_level !== 2'b11 || key_press !== 2'b11) begin
            bad++;
            $display("FAIL reset_held_press: level=%b press=%b required 11/11", key_level, key_press);
        end
        cycles(1);
        total++;
        if (key_press !== 2'b00) begin
            bad++;
            $display("FAIL reset_press_width: press=%b required 00", key_press);
        end
        key = 2'b00;
        t = cyc;
        expect_ev(t + LAT, 2'b00, 2'b11, 2'b00, 2'b00);
        cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL reset_event: missing, required cyc=%0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL reset_event: got cyc=%0d p=%b r=%b l=%b v=%b required cyc=%0d p=%b r=%b l=%b v=%b",
                             o.cyc, o.press, o.rel, o.lng, o.lvl, e.cyc, e.press, e.rel, e.lng, e.lvl);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL reset_extra: %0d unexpected events, required 0", obs_q.size());
            obs_q.delete();
        end
        $display("test_reset done at cyc=%0d", cyc);
    endtask

    task automatic test_press();
        int t;
        ev_t e, o;
        key = 2'b01;
        t = cyc;
        expect_ev(t + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        cycles(LAT - 1);
        total++;
        if (key_level !== 2'b00) begin
            bad++;
            $display("FAIL press_early: key_level=%b required 00", key_level);
        end
        cycles(1);
        total++;
        if (key_level !== 2'b01 || key_press !== 2'b01) begin
            bad++;
            $display("FAIL press_commit: level=%b press=%b required 01/01", key_level, key_press);
        end
        cycles(1);
        total++;
        if (key_press !== 2'b00) begin
            bad++;
            $display("FAIL press_width: press=%b required 00", key_press);
        end
        cycles(3);
        key = 2'b00;
        t = cyc;
        expect_ev(t + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL press_event: missing, required cyc=%0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL press_event: got cyc=%0d p=%b r=%b l=%b v=%b required cyc=%0d p=%b r=%b l=%b v=%b",
                             o.cyc, o.press, o.rel, o.lng, o.lvl, e.cyc, e.press, e.rel, e.lng, e.lvl);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL press_extra: %0d unexpected events, required 0", obs_q.size());
            obs_q.delete();
        end
        $display("test_press done at cyc=%0d", cyc);
    endtask

    task automatic test_glitch();
        key = 2'b01;
        cycles(DEB - 1);
        key = 2'b00;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            total++;
            if (key_level !== 2'b00 || key_press !== 2'b00) begin
                bad++;
                $display("FAIL glitch_reject: cyc=%0d level=%b press=%b required 00/00",
                         cyc, key_level, key_press);
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL glitch_extra: %0d unexpected events, required 0", obs_q.size());
            obs_q.delete();
        end
        $display("test_glitch done at cyc=%0d", cyc);
    endtask

    task automatic test_bounce();
        int t;
        ev_t e, o;
        logic [4:0] pat;
        pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            key = {1'b0, pat[i]};
            if (i < 4) cycles(1);
        end
        t = cyc;
        expect_ev(t + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        cycles(10);
        key = 2'b00;
        t = cyc;
        expect_ev(t + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL bounce_event: missing, required cyc=%0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL bounce_event: got cyc=%0d p=%b r=%b l=%b v=%b required cyc=%0d p=%b r=%b l=%b v=%b",
                             o.cyc, o.press, o.rel, o.lng, o.lvl, e.cyc, e.press, e.rel, e.lng, e.lvl);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL bounce_extra: %0d unexpected events, required 0", obs_q.size());
            obs_q.delete();
        end
        $display("test_bounce done at cyc=%0d", cyc);
    endtask

    task automatic test_long();
        int t;
        ev_t e, o;
        key = 2'b01;
        t = cyc;
        expect_ev(t + LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        // hold_cnt reaches LONG-1 fifteen edges after the press commit edge
        expect_ev(t + LAT + LONG_LAT, 2'b00, 2'b00, 2'b01, 2'b01);
        cycles(40);
        key = 2'b00;
        t = cyc;
        expect_ev(t + LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        cycles(30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL long_event: missing, required cyc=%0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL long_event: got cyc=%0d p=%b r=%b l=%b v=%b required cyc=%0d p=%b r=%b l=%b v=%b",
                             o.cyc, o.press, o.rel, o.lng, o.lvl, e.cyc, e.press, e.rel, e.lng, e.lvl);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL long_extra: %0d unexpected events, required 0", obs_q.size());
            obs_q.delete();
        end
        $display("test_long done at cyc=%0d", cyc);
    endtask

    task automatic test_back_to_back_reset();
        int t;
        ev_t e, o;
        key = 2'b11;
        t = cyc;
        expect_ev(t + LAT, 2'b11, 2'b00, 2'b00, 2'b11);
        cycles(10);
        gresetn = 1'b0;
        cycles(1);
        gresetn = 1'b1;
        total++;
        if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
            bad++;
            $display("FAIL midreset_clear: outputs=%b required 0",
                     {key_level, key_press, key_release, key_long});
        end
        t = cyc;
        expect_ev(t + LAT, 2'b11, 2'b00, 2'b00, 2'b11);
        cycles(9);
        key = 2'b00;
        t = cyc;
        expect_ev(t + LAT, 2'b00, 2'b11, 2'b00, 2'b00);
        cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL midreset_event: missing, required cyc=%0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL midreset_event: got cyc=%0d p=%b r=%b l=%b v=%b required cyc=%0d p=%b r=%b l=%b v=%b",
                             o.cyc, o.press, o.rel, o.lng, o.lvl, e.cyc, e.press, e.rel, e.lng, e.lvl);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_extra: %0d unexpected events, required 0", obs_q.size());
            obs_q.delete();
        end
        $display("test_back_to_back_reset done at cyc=%0d", cyc);
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_bounce();
        test_long();
        test_back_to_back_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
